// File: rtl/btb_update_queue.sv
// btb_update_queue: small FIFO of resolved taken-branch outcomes that drains
// one entry per cycle into the BTB write port. A push whose PC matches a
// queued entry (ignoring bit 0) overwrites that entry's target in place, so
// the BTB never receives a stale target.
// Optional macro BTB_UPQ_BYPASS_EN: when the queue is empty, a push is
// offered to the BTB in the same cycle and is not stored if it is accepted.
module btb_update_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic [15:0]                res_pc,
  input  logic [15:0]                res_target,
  input  logic                       upd_ready,
  output logic                       upd_valid,
  output logic [15:0]                upd_pc,
  output logic [15:0]                upd_target,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DEPTH-1:0][15:0]  pc_q, pc_d;
  logic [DEPTH-1:0][15:0]  tgt_q, tgt_d;
  logic [AW-1:0]           head_q, head_d;
  logic [AW-1:0]           tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    drop_q, drop_d;

  logic          push, q_valid, q_full, pop;
  logic          match_hit, coalesce, append, do_write, byp_take;
  logic [AW-1:0] match_idx;

  assign push    = res_valid & res_taken;
  assign q_valid = (count_q != '0);
  assign q_full  = (count_q == CW'(DEPTH));
  assign pop     = q_valid & upd_ready;

`ifdef BTB_UPQ_BYPASS_EN
  logic byp;
  assign byp        = push & ~q_valid;
  assign byp_take   = byp & upd_ready;
  assign upd_valid  = q_valid | byp;
  assign upd_pc     = byp ? res_pc     : pc_q[head_q];
  assign upd_target = byp ? res_target : tgt_q[head_q];
`else
  assign byp_take   = 1'b0;
  assign upd_valid  = q_valid;
  assign upd_pc     = pc_q[head_q];
  assign upd_target = tgt_q[head_q];
`endif

  assign count = count_q;
  assign full  = q_full;
  assign drop  = drop_q;

  // Find the (at most one) queued entry with the same branch tag as the push.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (pc_q[i][15:1] == res_pc[15:1])) begin
        match_hit = 1'b1;
        match_idx = AW'(i);
      end
    end
  end

  // A match on the head that is leaving this cycle must be re-appended,
  // otherwise the newer target would be lost with the popped entry.
  assign coalesce = push & match_hit & ~((match_idx == head_q) & pop);
  assign append   = push & ~coalesce;
  assign do_write = append & (~q_full | pop) & ~byp_take;

  // Next-state: coalesce overwrite, pop, then tail write (write wins when
  // a full queue pops and pushes into the slot just vacated).
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    drop_d  = append & q_full & ~pop;
    if (coalesce) begin
      tgt_d[match_idx] = res_target;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + AW'(1);
    end
    if (do_write) begin
      valid_d[tail_q] = 1'b1;
      pc_d[tail_q]    = res_pc;
      tgt_d[tail_q]   = res_target;
      tail_d          = tail_q + AW'(1);
    end
    count_d = count_q + CW'(do_write) - CW'(pop);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      pc_q    <= '0;
      tgt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

endmodule
